// File: rtl/fsm_3_if.sv
// AXI4 write-channel bundle (address, data control, response) for fsm_3.
// wdata is not carried here; it goes straight to the input FIFO.
interface fsm_3_if;
  logic [3:0]  awid;
  logic [15:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        awvalid;
  logic        awready;
  logic        wlast;
  logic        wvalid;
  logic        wready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awvalid,
    output wlast, wvalid, bready,
    input  awready, wready, bid, bresp, bvalid
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awvalid,
    input  wlast, wvalid, bready,
    output awready, wready, bid, bresp, bvalid
  );
endinterface

// File: rtl/fsm_3.sv
// AXI4 write-slave control FSM: accepts one AW burst, counts beats into the
// input FIFO, then returns a write response (SLVERR on burst/wlast errors).
module fsm_3 (
  input  logic        clk,
  input  logic        reset,
  fsm_3_if.slave      axs_s0,
  input  logic        in_fifo_full,
  output logic        in_fifo_push
);

  typedef enum logic [3:0] {
    INIT     = 4'b0001,
    AW_READY = 4'b0010,
    W_DATA   = 4'b0100,
    B_RESP   = 4'b1000
  } state_t;

  localparam logic [1:0] BURST_RSVD = 2'b11;
  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam logic [1:0] RESP_SLV   = 2'b10;

  state_t      state;
  logic [3:0]  awid_q;
  logic [15:0] awaddr_q;
  logic [7:0]  awlen_q;
  logic [2:0]  awsize_q;
  logic [1:0]  awburst_q;
  logic [7:0]  cnt;
  logic        err;

  logic        wready_c;
  logic        beat_acc;
  logic        last_beat;
  logic        unused_cap;

  // Captured address fields are held for downstream visibility only.
  assign unused_cap = ^{awaddr_q, awlen_q, awsize_q, awburst_q};

  assign wready_c  = (state == W_DATA) && !in_fifo_full;
  assign beat_acc  = wready_c && axs_s0.wvalid;
  assign last_beat = (cnt == 8'd0);

  always_comb begin
    axs_s0.awready = (state == AW_READY);
    axs_s0.wready  = wready_c;
    axs_s0.bvalid  = (state == B_RESP);
    axs_s0.bresp   = ((state == B_RESP) && err) ? RESP_SLV : RESP_OKAY;
    axs_s0.bid     = awid_q;
    in_fifo_push   = beat_acc;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= INIT;
      awid_q    <= '0;
      awaddr_q  <= '0;
      awlen_q   <= '0;
      awsize_q  <= '0;
      awburst_q <= '0;
      cnt       <= '0;
      err       <= 1'b0;
    end else begin
      case (state)
        INIT: begin
          awid_q    <= '0;
          awaddr_q  <= '0;
          awlen_q   <= '0;
          awsize_q  <= '0;
          awburst_q <= '0;
          cnt       <= '0;
          err       <= 1'b0;
          state     <= AW_READY;
        end
        AW_READY: begin
          // Fields track the bus every cycle; the handshake edge freezes them.
          awid_q    <= axs_s0.awid;
          awaddr_q  <= axs_s0.awaddr;
          awlen_q   <= axs_s0.awlen;
          awsize_q  <= axs_s0.awsize;
          awburst_q <= axs_s0.awburst;
          cnt       <= axs_s0.awlen;
          if (axs_s0.awvalid) begin
            if (axs_s0.awburst == BURST_RSVD) err <= 1'b1;
            state <= W_DATA;
          end
        end
        W_DATA: begin
          if (beat_acc) begin
            if (axs_s0.wlast != last_beat) err <= 1'b1;
            // Beat count, not wlast, ends the burst.
            if (last_beat) state <= B_RESP;
            else           cnt   <= cnt - 8'd1;
          end
        end
        B_RESP: begin
          if (axs_s0.bready) begin
            err   <= 1'b0;
            state <= AW_READY;
          end
        end
        default: state <= INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_fsm_3.sv
// Bench for fsm_3: directed cycle table, hand-written corner sequences and
// random bursts scored against a transaction-level response model.
module tb_fsm_3;
  logic clk;
  logic reset;
  logic in_fifo_full;
  logic in_fifo_push;
  int   total;
  int   passed;

  fsm_3_if axs_s0();

  fsm_3 dut (
    .clk          (clk),
    .reset        (reset),
    .axs_s0       (axs_s0),
    .in_fifo_full (in_fifo_full),
    .in_fifo_push (in_fifo_push)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       awv;
    logic [3:0] id;
    logic [7:0] len;
    logic [1:0] bur;
    logic       wv;
    logic       wl;
    logic       full;
    logic       br;
    logic [9:0] exp;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic awv, input logic [3:0] id, input logic [7:0] len,
                              input logic [1:0] bur, input logic wv, input logic wl,
                              input logic full, input logic br, input logic e_awr,
                              input logic e_wr, input logic e_push, input logic e_bv,
                              input logic [1:0] e_resp, input logic [3:0] e_bid);
    vec_t v;
    v.awv = awv; v.id = id; v.len = len; v.bur = bur;
    v.wv = wv; v.wl = wl; v.full = full; v.br = br;
    v.exp = {e_awr, e_wr, e_push, e_bv, e_resp, e_bid};
    return v;
  endfunction

  // {awready, wready, push, bvalid, bresp, bid}
  function automatic logic [9:0] outs();
    return {axs_s0.awready, axs_s0.wready, in_fifo_push, axs_s0.bvalid, axs_s0.bresp, axs_s0.bid};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  task automatic idle_inputs();
    axs_s0.awvalid = 0; axs_s0.awid = 0; axs_s0.awaddr = 0; axs_s0.awlen = 0;
    axs_s0.awsize = 0; axs_s0.awburst = 0; axs_s0.wvalid = 0; axs_s0.wlast = 0;
    axs_s0.bready = 0; in_fifo_full = 0;
  endtask

  // Response model: SLVERR iff reserved burst or any beat whose wlast
  // disagrees with "this is beat number awlen".
  function automatic logic [1:0] model_bresp(input logic [1:0] bur, input int len, input logic sent[$]);
    logic e;
    e = (bur == 2'b11);
    for (int i = 0; i < sent.size(); i++)
      if (sent[i] != (i == len)) e = 1'b1;
    return e ? 2'b10 : 2'b00;
  endfunction

  // Entered and left at posedge+1 with the DUT in AW_READY and awid_q == 0.
  task automatic run_burst(input logic [3:0] id, input int len, input logic [1:0] bur,
                           input int flip, input int full_pct, input int gap_pct, input int bdelay);
    logic sent[$];
    int   beat, npush;
    logic wv, fl;
    logic [1:0] eb;
    axs_s0.awvalid = 1; axs_s0.awid = id; axs_s0.awaddr = 16'($urandom);
    axs_s0.awlen = len[7:0]; axs_s0.awsize = 3'($urandom); axs_s0.awburst = bur;
    axs_s0.wvalid = 0; axs_s0.wlast = 0; axs_s0.bready = 0; in_fifo_full = 0;
    @(negedge clk);
    chk("aw_cycle", outs(), {4'b1000, 2'b00, 4'h0});
    @(posedge clk); #1;
    axs_s0.awvalid = 0; axs_s0.awid = 0; axs_s0.awlen = 0; axs_s0.awburst = 0;
    beat = 0; npush = 0;
    while (beat <= len) begin
      wv = ($urandom_range(99) >= gap_pct);
      fl = ($urandom_range(99) < full_pct);
      axs_s0.wvalid = wv;
      axs_s0.wlast  = ((beat == len) != (beat == flip));
      in_fifo_full  = fl;
      @(negedge clk);
      chk("wbeat", {axs_s0.awready, axs_s0.wready, in_fifo_push, axs_s0.bvalid, axs_s0.bid},
          {1'b0, !fl, wv && !fl, 1'b0, id});
      if (in_fifo_push === 1'b1) npush++;
      if (wv && !fl) begin
        sent.push_back(axs_s0.wlast);
        beat++;
      end
      @(posedge clk); #1;
    end
    chk("pushes", npush, len + 1);
    axs_s0.wvalid = 0; axs_s0.wlast = 0; in_fifo_full = 0;
    eb = model_bresp(bur, len, sent);
    for (int k = 0; k <= bdelay; k++) begin
      axs_s0.bready = (k == bdelay);
      @(negedge clk);
      chk("bresp_cycle", outs(), {4'b0001, eb, id});
      @(posedge clk); #1;
    end
    axs_s0.bready = 0;
    @(negedge clk);
    chk("back_aw", outs(), {4'b1000, 2'b00, id});
    @(posedge clk); #1;
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    logic [3:0] rid;
    int rlen, rflip;
    total = 0; passed = 0;
    idle_inputs();
    reset = 0;
    axs_s0.wvalid = 1;
    @(negedge clk);
    chk("in_reset", outs(), 10'h0);
    @(posedge clk); #1;
    reset = 1;
    @(negedge clk);
    chk("init_cycle", outs(), 10'h0);
    @(posedge clk); #1;
    axs_s0.wvalid = 0;

    // 4-beat burst, single-beat burst, FIFO-full stall on a 3-beat burst
    tbl.push_back(mk(1,5,3,1, 0,0,0,0, 1,0,0,0,0,0));
    tbl.push_back(mk(0,0,0,0, 1,0,0,0, 0,1,1,0,0,5));
    tbl.push_back(mk(0,0,0,0, 1,0,0,0, 0,1,1,0,0,5));
    tbl.push_back(mk(0,0,0,0, 1,0,0,0, 0,1,1,0,0,5));
    tbl.push_back(mk(0,0,0,0, 1,1,0,0, 0,1,1,0,0,5));
    tbl.push_back(mk(0,0,0,0, 0,0,0,1, 0,0,0,1,0,5));
    tbl.push_back(mk(0,5,0,0, 0,0,0,0, 1,0,0,0,0,5));
    tbl.push_back(mk(1,9,0,1, 0,0,0,0, 1,0,0,0,0,5));
    tbl.push_back(mk(0,0,0,0, 1,1,0,0, 0,1,1,0,0,9));
    tbl.push_back(mk(0,0,0,0, 0,0,0,1, 0,0,0,1,0,9));
    tbl.push_back(mk(1,3,2,1, 0,0,0,0, 1,0,0,0,0,9));
    tbl.push_back(mk(0,0,0,0, 1,0,0,0, 0,1,1,0,0,3));
    tbl.push_back(mk(0,0,0,0, 1,0,1,0, 0,0,0,0,0,3));
    tbl.push_back(mk(0,0,0,0, 1,0,1,0, 0,0,0,0,0,3));
    tbl.push_back(mk(0,0,0,0, 1,0,1,0, 0,0,0,0,0,3));
    tbl.push_back(mk(0,0,0,0, 1,0,0,0, 0,1,1,0,0,3));
    tbl.push_back(mk(0,0,0,0, 1,1,0,0, 0,1,1,0,0,3));
    tbl.push_back(mk(0,0,0,0, 0,0,0,1, 0,0,0,1,0,3));
    tbl.push_back(mk(0,0,0,0, 0,0,0,0, 1,0,0,0,0,3));

    for (int i = 0; i < tbl.size(); i++) begin
      axs_s0.awvalid = tbl[i].awv; axs_s0.awid = tbl[i].id; axs_s0.awlen = tbl[i].len;
      axs_s0.awburst = tbl[i].bur; axs_s0.wvalid = tbl[i].wv; axs_s0.wlast = tbl[i].wl;
      in_fifo_full = tbl[i].full; axs_s0.bready = tbl[i].br;
      @(negedge clk);
      chk($sformatf("vec%0d", i), outs(), tbl[i].exp);
      @(posedge clk); #1;
    end
    idle_inputs();

    // early wlast on beat 1 -> SLVERR, then a clean burst -> OKAY
    run_burst(4'h6, 2, 2'b01, 1, 0, 0, 0);
    run_burst(4'h7, 2, 2'b01, -1, 0, 0, 0);
    // reserved burst type, response held 4 cycles
    run_burst(4'hA, 1, 2'b11, -1, 0, 0, 4);

    // reset on the second beat of an 8-beat burst
    axs_s0.awvalid = 1; axs_s0.awid = 4'hC; axs_s0.awlen = 8'd7; axs_s0.awburst = 2'b01;
    @(negedge clk);
    chk("rst_aw", outs(), {4'b1000, 2'b00, 4'h0});
    @(posedge clk); #1;
    axs_s0.awvalid = 0; axs_s0.awid = 0; axs_s0.awlen = 0;
    axs_s0.wvalid = 1; axs_s0.wlast = 0;
    @(negedge clk);
    chk("rst_beat0", outs(), {4'b0110, 2'b00, 4'hC});
    @(posedge clk); #1;
    #2 reset = 0;
    #1;
    chk("rst_async", outs(), 10'h0);
    @(posedge clk); #1;
    chk("rst_held", outs(), 10'h0);
    reset = 1;
    @(negedge clk);
    chk("rst_init", outs(), 10'h0);
    @(posedge clk); #1;
    axs_s0.wvalid = 0;
    @(negedge clk);
    chk("rst_aw_ready", outs(), {4'b1000, 2'b00, 4'h0});
    @(posedge clk); #1;

    for (int n = 0; n < 40; n++) begin
      rid   = 4'($urandom_range(15));
      rlen  = ($urandom_range(19) == 0) ? 255 : $urandom_range(15);
      rflip = ($urandom_range(3) == 0) ? $urandom_range(rlen) : -1;
      run_burst(rid, rlen, 2'($urandom_range(3)), rflip, $urandom_range(50),
                $urandom_range(30), $urandom_range(5));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
